mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one registered 4-input data mux among four requesters in the MIPS32 datapath. It grants one requester at a time and holds the grant for a burst of beats. It drives the 2-bit mux select and registers the granted requester's data onto a single output with a valid flag. It enforces a maximum burst length so that no requester can starve the others.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/rr_prio4.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/rr_prio4.sv
// Rotating-priority picker: first requester at or above ptr, wrapping modulo 4.
module rr_prio4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down so the nearest-to-ptr request wins last.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    idx     = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a registered 4:1 data mux, with a bounded burst per grant.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [DATA_W-1:0]  in_data0,
  input  logic [DATA_W-1:0]  in_data1,
  input  logic [DATA_W-1:0]  in_data2,
  input  logic [DATA_W-1:0]  in_data3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid
);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [DATA_W-1:0]  out_data_nxt, owner_data;
  logic               out_valid_nxt;
  logic [SEL_W-1:0]   winner;
  logic               any_req;
  logic               beat, release_now;

  rr_prio4 u_prio (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    unique case (sel)
      2'd0:    owner_data = in_data0;
      2'd1:    owner_data = in_data1;
      2'd2:    owner_data = in_data2;
      default: owner_data = in_data3;
    endcase
  end

  // Abandon (no beat), owner's last, or hitting the burst cap all release exactly once.
  always_comb begin
    cnt_inc     = cnt + CNT_W'(1);
    beat        = req[sel];
    release_now = !beat || last[sel] || (cnt_inc == CNT_W'(MAX_BURST));
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    gnt_nxt       = gnt;
    sel_nxt       = sel;
    out_data_nxt  = out_data;
    out_valid_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (any_req) begin
          state_nxt = BUSY;
          gnt_nxt   = onehot(winner);
          sel_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (beat) begin
          out_data_nxt  = owner_data;
          out_valid_nxt = 1'b1;
          cnt_nxt       = cnt_inc;
        end
        if (release_now) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = sel + SEL_W'(1);
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      sel       <= sel_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench: dut_a (MAX_BURST=8) and dut_b (MAX_BURST=2) share clock, reset and data.
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_a, last_a, req_b, last_b;
  logic [31:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]  gnt_a, gnt_b;
  logic [1:0]  sel_a, sel_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic [31:0] din [4];

  int checks;
  int errors;

  initial begin
    din[0] = 32'h1111_0000;
    din[1] = 32'h2222_0001;
    din[2] = 32'hA5A5_0002;
    din[3] = 32'h3333_0003;
  end

  assign in_data0 = din[0];
  assign in_data1 = din[1];
  assign in_data2 = din[2];
  assign in_data3 = din[3];

  mux_rr_arbiter #(.DATA_W(32), .MAX_BURST(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .last(last_a),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .gnt(gnt_a), .sel(sel_a), .out_data(data_a), .out_valid(valid_a)
  );

  mux_rr_arbiter #(.DATA_W(32), .MAX_BURST(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .last(last_b),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .gnt(gnt_b), .sel(sel_b), .out_data(data_b), .out_valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_a = '0; last_a = '0; req_b = '0; last_b = '0;
    #12;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (gnt_a !== 4'b0000 || sel_a !== 2'd0 || valid_a !== 1'b0 || data_a !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: gnt=%b sel=%0d valid=%b data=%h, expected 0000/0/0/0",
                 c, gnt_a, sel_a, valid_a, data_a);
      end
      checks++;
      if (gnt_b !== 4'b0000 || valid_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_b cyc %0d: gnt=%b valid=%b, expected 0000/0", c, gnt_b, valid_b);
      end
    end
  endtask

  task automatic test_single_burst;
    req_a = 4'b0100; last_a = '0;
    tick();
    checks++;
    if (gnt_a !== 4'b0100 || sel_a !== 2'd2 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gnt=%b sel=%0d valid=%b, expected 0100/2/0", gnt_a, sel_a, valid_a);
    end
    for (int b = 1; b <= 3; b++) begin
      if (b == 3) last_a = 4'b0100;
      tick();
      checks++;
      if (valid_a !== 1'b1 || data_a !== 32'hA5A5_0002 ||
          gnt_a !== ((b < 3) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL single_beat%0d: valid=%b data=%h gnt=%b, expected 1/a5a50002/%b",
                 b, valid_a, data_a, gnt_a, (b < 3) ? 4'b0100 : 4'b0000);
      end
    end
    req_a = '0; last_a = '0;
    tick();
    checks++;
    if (valid_a !== 1'b0 || gnt_a !== 4'b0000) begin
      errors++;
      $display("FAIL single_after: valid=%b gnt=%b, expected 0/0000", valid_a, gnt_a);
    end
  endtask

  task automatic test_wrap;
    req_a = 4'b1001;
    tick();
    checks++;
    if (gnt_a !== 4'b1000 || sel_a !== 2'd3) begin
      errors++;
      $display("FAIL wrap_grant3: gnt=%b sel=%0d, expected 1000/3", gnt_a, sel_a);
    end
    last_a = 4'b1000;
    tick();
    checks++;
    if (valid_a !== 1'b1 || data_a !== 32'h3333_0003 || gnt_a !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_beat3: valid=%b data=%h gnt=%b, expected 1/33330003/0000",
               valid_a, data_a, gnt_a);
    end
    last_a = '0;
    tick();
    checks++;
    if (gnt_a !== 4'b0001 || sel_a !== 2'd0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL wrap_grant0: gnt=%b sel=%0d valid=%b, expected 0001/0/0", gnt_a, sel_a, valid_a);
    end
    req_a = '0;
    tick();
    checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL wrap_abandon: gnt=%b valid=%b, expected 0000/0", gnt_a, valid_a);
    end
  endtask

  task automatic test_drop;
    req_a = 4'b0110;
    tick();
    checks++;
    if (gnt_a !== 4'b0010 || sel_a !== 2'd1) begin
      errors++;
      $display("FAIL drop_grant1: gnt=%b sel=%0d, expected 0010/1", gnt_a, sel_a);
    end
    tick();
    checks++;
    if (valid_a !== 1'b1 || data_a !== 32'h2222_0001) begin
      errors++;
      $display("FAIL drop_beat1: valid=%b data=%h, expected 1/22220001", valid_a, data_a);
    end
    req_a = 4'b0100;
    tick();
    checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: gnt=%b valid=%b, expected 0000/0", gnt_a, valid_a);
    end
    tick();
    checks++;
    if (gnt_a !== 4'b0100 || sel_a !== 2'd2) begin
      errors++;
      $display("FAIL drop_next: gnt=%b sel=%0d, expected 0100/2", gnt_a, sel_a);
    end
    req_a = '0;
    tick();
    checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: gnt=%b valid=%b, expected 0000/0", gnt_a, valid_a);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    int         w;
    req_b = 4'b1111; last_b = '0;
    for (int g = 0; g < 5; g++) begin
      w     = g % 4;
      exp_g = 4'b0001 << w;
      tick();
      checks++;
      if (gnt_b !== exp_g || sel_b !== 2'(w) || valid_b !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b sel=%0d valid=%b, expected %b/%0d/0",
                 g, gnt_b, sel_b, valid_b, exp_g, w);
      end
      tick();
      checks++;
      if (valid_b !== 1'b1 || data_b !== din[w] || gnt_b !== exp_g) begin
        errors++;
        $display("FAIL rr_beat1_%0d: valid=%b data=%h gnt=%b, expected 1/%h/%b",
                 g, valid_b, data_b, gnt_b, din[w], exp_g);
      end
      tick();
      checks++;
      if (valid_b !== 1'b1 || data_b !== din[w] || gnt_b !== 4'b0000) begin
        errors++;
        $display("FAIL rr_beat2_%0d: valid=%b data=%h gnt=%b, expected 1/%h/0000",
                 g, valid_b, data_b, gnt_b, din[w]);
      end
    end
    req_b = '0;
    tick();
    checks++;
    if (gnt_b !== 4'b0000 || valid_b !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: gnt=%b valid=%b, expected 0000/0", gnt_b, valid_b);
    end
  endtask

  task automatic test_last_and_forced;
    req_b = 4'b0100; last_b = '0;
    tick();
    checks++;
    if (gnt_b !== 4'b0100) begin
      errors++;
      $display("FAIL lf_grant: gnt=%b, expected 0100", gnt_b);
    end
    tick();
    last_b = 4'b0100;
    tick();
    checks++;
    if (valid_b !== 1'b1 || data_b !== 32'hA5A5_0002 || gnt_b !== 4'b0000) begin
      errors++;
      $display("FAIL lf_release: valid=%b data=%h gnt=%b, expected 1/a5a50002/0000",
               valid_b, data_b, gnt_b);
    end
    req_b = 4'b1100; last_b = '0;
    tick();
    checks++;
    if (gnt_b !== 4'b1000 || sel_b !== 2'd3) begin
      errors++;
      $display("FAIL lf_ptr_once: gnt=%b sel=%0d, expected 1000/3", gnt_b, sel_b);
    end
    req_b = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst;
    req_a = 4'b0001; last_a = '0;
    tick();
    checks++;
    if (gnt_a !== 4'b0001) begin
      errors++;
      $display("FAIL rst_grant: gnt=%b, expected 0001", gnt_a);
    end
    tick();
    tick();
    checks++;
    if (valid_a !== 1'b1 || data_a !== 32'h1111_0000) begin
      errors++;
      $display("FAIL rst_beat2: valid=%b data=%h, expected 1/11110000", valid_a, data_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || data_a !== 32'h0 || sel_a !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: gnt=%b valid=%b data=%h sel=%0d, expected 0000/0/0/0",
               gnt_a, valid_a, data_a, sel_a);
    end
    req_a = 4'b1111;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (gnt_a !== 4'b0001 || sel_a !== 2'd0) begin
      errors++;
      $display("FAIL rst_restart: gnt=%b sel=%0d, expected 0001/0", gnt_a, sel_a);
    end
    req_a = '0;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_burst();
    test_wrap();
    test_drop();
    test_round_robin();
    test_last_and_forced();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
